// File: rtl/adc_drp_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_drp_responder_if
//  Description : DRP-style access port (den/dwe/daddr/di -> drdy/do) between
//                a host-side initiator and the ADC register responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_drp_responder_if;
   logic        den_in;
   logic        dwe_in;
   logic [6:0]  daddr_in;
   logic [15:0] di_in;
   logic        drdy_out;
   logic [15:0] do_out;
   logic        busy_out;
   logic        err_out;

   modport master (
      output den_in, dwe_in, daddr_in, di_in,
      input  drdy_out, do_out, busy_out, err_out
   );

   modport slave (
      input  den_in, dwe_in, daddr_in, di_in,
      output drdy_out, do_out, busy_out, err_out
   );
endinterface
`default_nettype wire

// File: rtl/adc_drp_responder.sv
`default_nettype none
// ============================================================================
//  Module      : adc_drp_responder
//  Description : DRP register responder exposing XADC / PWM / R2R samples,
//                per-channel sample counters, sticky status flags, a control
//                register and an ID word. Optional sample timestamping is
//                built when ADC_DRP_TIMESTAMP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_drp_responder #(
   parameter int          READ_LATENCY = 2,
   parameter logic [15:0] ID_VALUE     = 16'hADC1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   adc_drp_responder_if.slave    drp,
   input  wire logic             xadc_ready,
   input  wire logic             pwm_ready,
   input  wire logic             r2r_ready,
   input  wire logic [15:0]      xadc_data,
   input  wire logic [15:0]      pwm_data,
   input  wire logic [15:0]      r2r_data,
   output      logic [15:0]      ctrl_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [6:0] A_STATUS = 7'h08;
   localparam logic [6:0] A_CTRL   = 7'h10;
   localparam logic [6:0] A_ID     = 7'h1F;
   localparam logic [3:0] C_WAIT_LOAD = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

   logic [1:0]  r_state, w_state_next;
   logic [3:0]  r_wait;
   logic [15:0] r_do;
   logic        r_err_pend;

   logic [15:0] r_data [0:2];
   logic [15:0] r_cnt  [0:2];
   logic [2:0]  r_new;
   logic [2:0]  r_ovr;
   logic        r_coll;

   logic [2:0]  w_ready;
   logic [15:0] w_sample [0:2];
   logic        w_accept, w_rd, w_wr, w_coll, w_mapped;
   logic [15:0] w_rdata;

   assign w_ready     = {r2r_ready, pwm_ready, xadc_ready};
   assign w_sample[0] = xadc_data;
   assign w_sample[1] = pwm_data;
   assign w_sample[2] = r2r_data;

   assign w_accept = drp.den_in && (r_state == S_IDLE);
   assign w_rd     = w_accept && !drp.dwe_in;
   assign w_wr     = w_accept && drp.dwe_in;
   assign w_coll   = drp.den_in && (r_state != S_IDLE);

`ifdef ADC_DRP_TIMESTAMP_EN
   logic [31:0] r_cycle;
   logic [31:0] r_ts;
   logic [15:0] r_ts_hi;

   // Free-running cycle count, XADC timestamp latch, and high-half snapshot
   // taken on a low-half read so 0x0C/0x0D form a coherent pair.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cycle <= '0;
         r_ts    <= '0;
         r_ts_hi <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (xadc_ready)
            r_ts <= r_cycle;
         if (w_rd && (drp.daddr_in == 7'h0C))
            r_ts_hi <= r_ts[31:16];
      end
   end
`endif

   // Register-map read decode; unmapped addresses read zero.
   always_comb begin
      w_rdata  = '0;
      w_mapped = 1'b1;
      case (drp.daddr_in)
         7'h00:    w_rdata = r_data[0];
         7'h01:    w_rdata = r_data[1];
         7'h02:    w_rdata = r_data[2];
         7'h04:    w_rdata = r_cnt[0];
         7'h05:    w_rdata = r_cnt[1];
         7'h06:    w_rdata = r_cnt[2];
         A_STATUS: w_rdata = {9'd0, r_coll, r_ovr, r_new};
         A_CTRL:   w_rdata = ctrl_out;
         A_ID:     w_rdata = ID_VALUE;
`ifdef ADC_DRP_TIMESTAMP_EN
         7'h0C:    w_rdata = r_ts[15:0];
         7'h0D:    w_rdata = r_ts_hi;
`endif
         default:  w_mapped = 1'b0;
      endcase
   end

   // Per-channel capture, counters and sticky flags; a set always beats a
   // same-cycle clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            r_data[i] <= '0;
            r_cnt[i]  <= '0;
         end
         r_new  <= '0;
         r_ovr  <= '0;
         r_coll <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (w_ready[i]) begin
               r_data[i] <= w_sample[i];
               r_cnt[i]  <= r_cnt[i] + 16'd1;
               r_new[i]  <= 1'b1;
            end else if (w_rd && (drp.daddr_in == 7'(i))) begin
               r_new[i]  <= 1'b0;
            end
            if (w_ready[i] && r_new[i])
               r_ovr[i] <= 1'b1;
            else if (w_wr && (drp.daddr_in == A_STATUS) && drp.di_in[3+i])
               r_ovr[i] <= 1'b0;
         end
         if (w_coll)
            r_coll <= 1'b1;
         else if (w_wr && (drp.daddr_in == A_STATUS) && drp.di_in[6])
            r_coll <= 1'b0;
      end
   end

   // Control register, response snapshot and latency counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_out   <= '0;
         r_do       <= '0;
         r_err_pend <= 1'b0;
         r_wait     <= '0;
      end else begin
         if (w_wr && (drp.daddr_in == A_CTRL))
            ctrl_out <= drp.di_in;
         if (w_accept) begin
            r_do       <= w_rdata;
            r_err_pend <= !w_mapped;
            r_wait     <= C_WAIT_LOAD;
         end else if ((r_state == S_WAIT) && (r_wait != 4'd0)) begin
            r_wait <= r_wait - 4'd1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // FSM next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT:  if (r_wait == 4'd0) w_state_next = S_RESP;
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs; do_out holds the last snapshot outside RESP.
   always_comb begin
      drp.drdy_out = (r_state == S_RESP);
      drp.busy_out = (r_state != S_IDLE);
      drp.err_out  = (r_state == S_RESP) && r_err_pend;
      drp.do_out   = r_do;
   end

endmodule
`default_nettype wire

// File: doc/adc_drp_responder.md
# adc_drp_responder

DRP-style register responder that exposes the results of the three ADC paths (XADC, PWM ramp, R2R) to a host-side DRP initiator, mirroring the den/dwe/daddr/di → drdy/do handshake the design already drives into the XADC primitive. It captures each ADC's sample on its ready pulse, keeps per-channel sample counters and sticky status flags, and holds a host-writable control register. It sits beside the ADC processing blocks at top level, and a future host bridge connects to its DRP port.

## Interface
- READ_LATENCY, 2: cycles from accepted den_in to drdy_out; legal range 1..15.
- ID_VALUE, 16'hADC1: constant returned at address 0x1F.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-low reset.
- den_in  in  1  access strobe, one-cycle pulse.
- dwe_in  in  1  write enable, qualified by den_in.
- daddr_in  in  7  register address.
- di_in  in  16  write data.
- drdy_out  out  1  one-cycle response strobe.
- do_out  out  16  read data, valid when drdy_out=1.
- busy_out  out  1  access in flight.
- err_out  out  1  one-cycle pulse, coincident with drdy_out, on an unmapped access.
- xadc_ready, pwm_ready, r2r_ready  in  1 each  one-cycle sample-valid pulses.
- xadc_data, pwm_data, r2r_data  in  16 each  sample values.
- ctrl_out  out  16  control register contents.

## Operation
- Register map:
  - 0x00/0x01/0x02: latest XADC/PWM/R2R sample (RO).
  - 0x04/0x05/0x06: 16-bit sample counters (RO). Each counter increments on its ready pulse and wraps from 0xFFFF to 0x0000.
  - 0x08: status register.
    - Bits [2:0]: new-data flags, in order XADC/PWM/R2R. A flag sets on its ready pulse. Reading the matching data register clears it.
    - Bits [5:3]: overrun flags. An overrun flag sets when a ready pulse arrives while the matching new-data flag is already set.
    - Bit 6: collision flag. Sets when den_in arrives while busy_out=1.
    - Bits [6:3] are write-1-to-clear. Bits [2:0] ignore writes.
  - 0x10: control register (RW).
  - 0x1F: ID (RO).
- Writes to RO addresses are ignored with no error. An unmapped read returns 0x0000 and raises err_out. An unmapped write raises err_out.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on den_in, the access is accepted. Read data is snapshotted and side effects (flag clears, writes) are applied in the same cycle. Next state is WAIT, or RESP if READ_LATENCY=1.
  - WAIT: a down-counter runs for READ_LATENCY-1 cycles, then the FSM goes to RESP.
  - RESP: drdy_out=1 and do_out=snapshot for one cycle, then the FSM returns to IDLE.
- den_in while not IDLE: the access is ignored (no write, no response) and status bit 6 sets.
- Simultaneous events:
  - Ready pulse in the same cycle as a read of that data register: the snapshot returns the old value, the register updates, and the new-data flag stays set (set wins).
  - W1C write and flag set in the same cycle: set wins.
  - Write and a ready pulse to different registers in the same cycle: both take effect.
- do_out holds its last value outside RESP. It is meaningful only while drdy_out=1.
- A ready pulse updates its data register, counter and flags regardless of FSM state.

## Timing
- Reset values: drdy_out=0, do_out=0, busy_out=0, err_out=0, ctrl_out=0x0000. All data registers, counters and flags are 0. FSM is in IDLE.
- den_in at cycle N gives drdy_out at cycle N+READ_LATENCY.
- busy_out is high from N+1 through N+READ_LATENCY inclusive.
- A new den_in is accepted no earlier than cycle N+READ_LATENCY+1.
- A write to ctrl_out is visible at N+1.
- A ready pulse at cycle M makes the data, counter and flags visible to an access accepted at M+1.
- Reset asserted mid-access aborts the access: no drdy_out is issued, and all state returns to reset values on the next edge.

## Configuration
- ADC_DRP_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter is added, reset to 0.
  - On each xadc_ready, its value is latched into a timestamp.
  - The timestamp reads at 0x0C (bits [15:0]) and 0x0D (bits [31:16]).
  - A read of 0x0C also snapshots the high half, so that a following read of 0x0D returns the matching upper word.
- Undefined: 0x0C and 0x0D are unmapped (read 0x0000, err_out pulses) and no counter logic is built.

## Test plan
- Reset release, then read 0x1F with READ_LATENCY=2: drdy_out is high exactly 2 cycles after den_in, do_out=0xADC1, busy_out is high for 2 cycles, err_out=0.
- pwm_ready with pwm_data=0x0123, then read 0x08 → 0x0002. Read 0x01 → 0x0123. Read 0x08 again → 0x0000. Read 0x05 → 0x0001.
- Two xadc_ready pulses with no read in between: status reads 0x0009. Write 0x0008 to 0x08: status reads 0x0001.
- Write 0xBEEF to 0x10, then read 0x10 → 0xBEEF. ctrl_out=0xBEEF from the cycle after den_in. A den_in to 0x33 gives do_out=0, err_out=1.
- den_in issued while busy_out=1: no second drdy_out, ctrl_out unchanged, status bit 6 set. Then reset (reset=0) during WAIT: drdy_out never asserts and all outputs are 0.
- With ADC_DRP_TIMESTAMP_EN: xadc_ready at counter value 0x0001_0005, then read 0x0C → 0x0005 and read 0x0D → 0x0001. Without the macro: reading 0x0C gives err_out=1.
